fft_mem_sequencer: RTL
======================

# fft_mem_sequencer

In-place radix-2 decimation-in-time (DIT) FFT address sequencer for the FFT pipeline's dual-port working memory. On a start pulse it walks all log2(N) stages and issues one butterfly per cycle: two reads, a twiddle index, and the matching two writes after the butterfly latency. It inserts drain cycles between stages to prevent read-after-write hazards. It sits between the FFT top-level control and the dual-port RAM / butterfly datapath. Input data is already resident in RAM in bit-reversed order.

## Interface
- N_POINTS, 32, FFT length; a power of two, ≥4
- ADDR_SIZE, $clog2(N_POINTS), RAM address width
- BF_LATENCY, 2, cycles from RAM read data to butterfly result; ≥1
- i_CLK  in  1  single clock
- i_RST  in  1  reset; synchronous, active-high
- i_start  in  1  start request; accepted only in IDLE
- o_busy  out  1  high from the cycle after start acceptance until DONE inclusive
- o_done  out  1  one-cycle pulse when the last write has committed
- o_stage  out  $clog2(ADDR_SIZE)+1  current stage index
- o_read_en_A, o_read_en_B  out  1  read enables, always asserted together
- o_read_addr_A, o_read_addr_B  out  ADDR_SIZE  butterfly top and bottom addresses
- o_tw_addr  out  ADDR_SIZE-1  twiddle ROM index for the issued butterfly
- o_write_en_A, o_write_en_B  out  1  write enables, always asserted together
- o_write_addr_A, o_write_addr_B  out  ADDR_SIZE  write-back addresses

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ on i_start. Stage and butterfly counter b are cleared.
  - READ: issue one butterfly per cycle for b = 0 … N/2−1. After b = N/2−1, go to DRAIN and clear b.
  - DRAIN: lasts exactly BF_LATENCY cycles. Then, if stage = log2(N)−1, go to DONE; otherwise increment stage and return to READ.
  - DONE: lasts one cycle, then IDLE.
- Address generation for stage s, span = 2^s:
  - A = ((b >> s) << (s+1)) | (b & (span−1))
  - B = A + span
  - tw = (b & (span−1)) << (log2(N)−1−s)
  - All arithmetic is unsigned and modulo-free. The B address never overflows.
- Write-back delay line:
  - BF_LATENCY-deep shift register of {valid, A, B}, shifted every cycle.
  - Valid is loaded with the READ-state issue flag.
  - o_write_en_A/B equals the tail valid bit; o_write_addr_A/B equals the tail addresses.
- Read enables and addresses are driven only in READ. Outside READ, read enables are 0 and read addresses are 0.
- i_start is ignored while not in IDLE, including the DONE cycle.
- The block never writes without a corresponding read BF_LATENCY cycles earlier.

## Timing
- Reset values: all outputs 0, FSM in IDLE, delay line cleared.
- Reset mid-operation:
  - Effective at the next edge.
  - Pending writes in the delay line are discarded; no write enable is asserted after reset.
  - o_done does not pulse.
- Start latency: i_start is sampled high in IDLE at edge k. From cycle k+1 the FSM is in READ, o_busy = 1, and the first read is issued.
- Read behavior: the RAM reads asynchronously, so addresses and o_tw_addr for a butterfly are valid in the same cycle the read is issued.
- Write timing: a read issued in cycle t produces write enables and the same A/B addresses in cycle t+BF_LATENCY. The write commits at the end of that cycle.
- Stage boundary:
  - Last read of stage s in cycle t.
  - Last write in cycle t+BF_LATENCY.
  - First read of stage s+1 in cycle t+BF_LATENCY+1.
  - No gap beyond this; no overlap.
- Totals:
  - o_busy duration: log2(N)·(N/2 + BF_LATENCY) + 1 cycles.
  - For N = 32 and BF_LATENCY = 2, that is 5·18 + 1 = 91 cycles.
  - o_done is high in the final busy cycle.
- o_stage is valid during READ/DRAIN and holds the final stage value in DONE.

## Test plan
- Reset and idle: assert i_RST for 3 cycles, then hold i_start = 0 → all outputs 0, o_busy = 0, and no enables for 20 cycles.
- Address pattern (N = 32):
  - Stage 0, b = 5 → A = 10, B = 11, tw = 0.
  - Stage 2, b = 5 → A = 9, B = 13, tw = 4.
  - Stage 4, b = 15 → A = 15, B = 31, tw = 15.
  - Scoreboard all 80 butterflies against the formula.
- Write delay and drain (BF_LATENCY = 2):
  - Each write enable appears exactly 2 cycles after its read, with identical addresses.
  - Exactly 2 cycles separate the last stage-0 read from the first stage-1 read.
  - A RAM model running a reference butterfly produces the golden FFT of an impulse (all-ones output).
- Full run: pulse i_start once → o_busy high for 91 cycles, o_done pulses once in cycle 91, and totals are 80 read cycles and 80 write cycles.
- Start while busy: pulse i_start at cycles 10 and at the DONE cycle → ignored, sequence and cycle counts unchanged. A start one cycle after DONE begins a new run.
- Reset mid-run: assert i_RST in cycle 40 (stage 2) with writes pending → no write enables after reset, no o_done pulse. A subsequent i_start runs a complete 91-cycle sequence.

Source files
------------

// File: rtl/fft_mem_sequencer_if.sv
// Control and RAM-side bus of the in-place radix-2 DIT FFT address sequencer.
// The master side is the FFT top-level control plus RAM/butterfly datapath,
// the slave side is the sequencer itself.
interface fft_mem_sequencer_if #(
  parameter int N_POINTS = 32
);
  localparam int ADDR_SIZE = $clog2(N_POINTS);
  localparam int STAGE_W   = $clog2(ADDR_SIZE) + 1;

  logic                 i_start;
  logic                 o_busy;
  logic                 o_done;
  logic [STAGE_W-1:0]   o_stage;
  logic                 o_read_en_A;
  logic                 o_read_en_B;
  logic [ADDR_SIZE-1:0] o_read_addr_A;
  logic [ADDR_SIZE-1:0] o_read_addr_B;
  logic [ADDR_SIZE-2:0] o_tw_addr;
  logic                 o_write_en_A;
  logic                 o_write_en_B;
  logic [ADDR_SIZE-1:0] o_write_addr_A;
  logic [ADDR_SIZE-1:0] o_write_addr_B;

  modport master (
    output i_start,
    input  o_busy, o_done, o_stage,
    input  o_read_en_A, o_read_en_B, o_read_addr_A, o_read_addr_B, o_tw_addr,
    input  o_write_en_A, o_write_en_B, o_write_addr_A, o_write_addr_B
  );

  modport slave (
    input  i_start,
    output o_busy, o_done, o_stage,
    output o_read_en_A, o_read_en_B, o_read_addr_A, o_read_addr_B, o_tw_addr,
    output o_write_en_A, o_write_en_B, o_write_addr_A, o_write_addr_B
  );
endinterface

// File: rtl/fft_mem_sequencer.sv
// In-place radix-2 DIT FFT address sequencer. Walks log2(N) stages issuing one
// butterfly per cycle, replays each butterfly's addresses as a write after the
// butterfly latency, and drains the pipe between stages so a stage never reads
// a location the previous stage has yet to write back.
module fft_mem_sequencer #(
  parameter int N_POINTS   = 32,
  parameter int ADDR_SIZE  = $clog2(N_POINTS),
  parameter int BF_LATENCY = 2
) (
  input logic            i_CLK,
  input logic            i_RST,
  fft_mem_sequencer_if.slave bus
);
  localparam int STAGE_W = $clog2(ADDR_SIZE) + 1;
  localparam int BFLY_W  = ADDR_SIZE - 1;
  localparam int DRAIN_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'(N_POINTS / 2 - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(ADDR_SIZE - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(BF_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [BFLY_W-1:0]    bfly_q, bfly_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;

  logic                 rdEn_q;
  logic [ADDR_SIZE-1:0] addrA_q, addrA_d;
  logic [ADDR_SIZE-1:0] addrB_q, addrB_d;
  logic [BFLY_W-1:0]    tw_q, tw_d;
  logic                 busy_q;
  logic                 done_q;

  logic [ADDR_SIZE-1:0] bExt, spanMask, lowBits;

  logic [BF_LATENCY-1:0]                wrValid_q;
  logic [BF_LATENCY-1:0][ADDR_SIZE-1:0] wrA_q;
  logic [BF_LATENCY-1:0][ADDR_SIZE-1:0] wrB_q;

  // Next state of the stage walk, plus the addresses of the butterfly issued next cycle
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    bfly_d   = bfly_q;
    drain_d  = drain_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = READ;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      READ: begin
        if (bfly_q == LAST_BFLY) begin
          state_d = DRAIN;
          bfly_d  = '0;
          drain_d = '0;
        end else begin
          bfly_d = bfly_q + BFLY_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    bExt     = ADDR_SIZE'(bfly_d);
    spanMask = (ADDR_SIZE'(1) << stage_d) - ADDR_SIZE'(1);
    lowBits  = bExt & spanMask;
    addrA_d  = '0;
    addrB_d  = '0;
    tw_d     = '0;
    if (state_d == READ) begin
      addrA_d = ((bExt >> stage_d) << (stage_d + STAGE_W'(1))) | lowBits;
      addrB_d = addrA_d + (ADDR_SIZE'(1) << stage_d);
      tw_d    = BFLY_W'(lowBits << (LAST_STAGE - stage_d));
    end
  end

  // State, registered read-side outputs and the write-back delay line
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      bfly_q    <= '0;
      drain_q   <= '0;
      rdEn_q    <= 1'b0;
      addrA_q   <= '0;
      addrB_q   <= '0;
      tw_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrValid_q <= '0;
      wrA_q     <= '0;
      wrB_q     <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      drain_q   <= drain_d;
      rdEn_q    <= (state_d == READ);
      addrA_q   <= addrA_d;
      addrB_q   <= addrB_d;
      tw_q      <= tw_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      wrValid_q[0] <= rdEn_q;
      wrA_q[0]     <= addrA_q;
      wrB_q[0]     <= addrB_q;
      for (int i = 1; i < BF_LATENCY; i++) begin
        wrValid_q[i] <= wrValid_q[i-1];
        wrA_q[i]     <= wrA_q[i-1];
        wrB_q[i]     <= wrB_q[i-1];
      end
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_stage        = stage_q;
  assign bus.o_read_en_A    = rdEn_q;
  assign bus.o_read_en_B    = rdEn_q;
  assign bus.o_read_addr_A  = addrA_q;
  assign bus.o_read_addr_B  = addrB_q;
  assign bus.o_tw_addr      = tw_q;
  assign bus.o_write_en_A   = wrValid_q[BF_LATENCY-1];
  assign bus.o_write_en_B   = wrValid_q[BF_LATENCY-1];
  assign bus.o_write_addr_A = wrA_q[BF_LATENCY-1];
  assign bus.o_write_addr_B = wrB_q[BF_LATENCY-1];
endmodule
